// File: rtl/dcn_seq.sv
// rtl/dcn_seq.sv - registered binary-to-one-hot decoder with select sequencer
//
// Decodes a W-bit select register onto COUNT one-hot outputs.
// The select register either follows `a` (direct mode) or is loaded and
// stepped with wrap-around (scan mode).
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   ena   - global enable; low freezes sel and zeroes d/wrap/err
//   mode  - 0 = direct, 1 = scan
//   load  - scan: load `a` into sel (wins over step)
//   step  - scan: move sel one position
//   up    - step direction, 1 = increment
//   a     - select value (direct) or load value (scan)
//   d     - registered one-hot decode of sel
//   sel   - current select register
//   wrap  - one-cycle pulse when a step wraps around
//   err   - one-cycle pulse when `a` is out of range
module dcn_seq #(
   parameter int W     = 3,
   parameter int COUNT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             mode,
   input  logic             load,
   input  logic             step,
   input  logic             up,
   input  logic [W-1:0]     a,
   output logic [COUNT-1:0] d,
   output logic [W-1:0]     sel,
   output logic             wrap,
   output logic             err
);

   // COUNT may equal 2**W, so the range check needs one extra bit.
   localparam logic [W:0]   COUNT_W = (W+1)'(COUNT);
   localparam logic [W-1:0] LAST    = W'(COUNT - 1);

   logic [W-1:0]     sel_q, sel_d;
   logic [COUNT-1:0] d_q, d_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic             a_ok;

   always_comb begin
      sel_d  = sel_q;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      d_d    = '0;
      a_ok   = ({1'b0, a} < COUNT_W);

      if (ena) begin
         if (!mode || load) begin
            // Direct mode and scan-load share the same range-checked load.
            // In scan mode a rejected load still swallows any step.
            if (a_ok) begin
               sel_d = a;
            end else begin
               err_d = 1'b1;
            end
         end else if (step) begin
            // Wrap is detected by comparing against the end points, so
            // a non-power-of-two COUNT never relies on W-bit overflow.
            if (up) begin
               if (sel_q == LAST) begin
                  sel_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  sel_d = sel_q + W'(1);
               end
            end else begin
               if (sel_q == '0) begin
                  sel_d  = LAST;
                  wrap_d = 1'b1;
               end else begin
                  sel_d = sel_q - W'(1);
               end
            end
         end

         for (int i = 0; i < COUNT; i++) begin
            d_d[i] = (sel_d == W'(i));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q  <= '0;
         d_q    <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         sel_q  <= sel_d;
         d_q    <= d_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign d    = d_q;
   assign sel  = sel_q;
   assign wrap = wrap_q;
   assign err  = err_q;

endmodule

// File: tb/tb_dcn_seq.sv
// tb/tb_dcn_seq.sv - self-checking bench for dcn_seq (W=3, COUNT=6)
module tb_dcn_seq;

   localparam int W     = 3;
   localparam int COUNT = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             ena = 1'b0;
   logic             mode = 1'b0;
   logic             load = 1'b0;
   logic             step = 1'b0;
   logic             up = 1'b0;
   logic [W-1:0]     a = '0;
   logic [COUNT-1:0] d;
   logic [W-1:0]     sel;
   logic             wrap;
   logic             err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [COUNT-1:0] d;
      logic [W-1:0]     sel;
      logic             wrap;
      logic             err;
      string            tag;
   } exp_t;

   exp_t sb[$];
   int   m_sel = 0;

   dcn_seq #(.W(W), .COUNT(COUNT)) dut (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .mode (mode),
      .load (load),
      .step (step),
      .up   (up),
      .a    (a),
      .d    (d),
      .sel  (sel),
      .wrap (wrap),
      .err  (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, push the model's expectation, then
   // clock and compare the DUT output against the popped entry.
   task automatic cycle(input logic e, input logic m, input logic l,
                        input logic s, input logic u, input logic [W-1:0] av,
                        input string tag);
      exp_t x;
      exp_t got;
      int   ns;
      ena = e; mode = m; load = l; step = s; up = u; a = av;
      ns     = m_sel;
      x.wrap = 1'b0;
      x.err  = 1'b0;
      if (e) begin
         if (!m || l) begin
            if (int'(av) < COUNT) ns = int'(av);
            else x.err = 1'b1;
         end else if (s) begin
            if (u) begin
               x.wrap = (m_sel == COUNT - 1);
               ns = (m_sel + 1) % COUNT;
            end else begin
               x.wrap = (m_sel == 0);
               ns = (m_sel + COUNT - 1) % COUNT;
            end
         end
      end
      m_sel = ns;
      x.sel = W'(ns);
      x.d   = e ? (COUNT'(1) << ns) : '0;
      x.tag = tag;
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         got = sb.pop_front();
         checks++;
         assert ({d, sel, wrap, err} === {got.d, got.sel, got.wrap, got.err}) else begin
            errors++;
            $error("FAIL %s: observed d=%b sel=%0d wrap=%b err=%b expected d=%b sel=%0d wrap=%b err=%b",
                   got.tag, d, sel, wrap, err, got.d, got.sel, got.wrap, got.err);
         end
      end
   endtask

   initial begin
      // 1. async reset mid-cycle, then direct load of 4
      #2 rst = 1'b1;
      #1;
      chk("rst_imm", {d, sel, wrap, err}, 16'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_sel = 0;
      cycle(1, 0, 0, 0, 0, 3'd4, "dir4");
      chk("dir4_d", 16'(d), 16'b010000);
      chk("dir4_sel", 16'(sel), 16'd4);

      // 2. direct out of range, err for exactly one cycle
      cycle(1, 0, 0, 0, 0, 3'd7, "dir_oor");
      chk("dir_oor_err", 16'(err), 16'd1);
      chk("dir_oor_sel", 16'(sel), 16'd4);
      chk("dir_oor_d", 16'(d), 16'b010000);
      cycle(1, 0, 0, 0, 0, 3'd4, "dir_after");
      chk("dir_err_clear", 16'(err), 16'd0);
      cycle(1, 0, 0, 0, 0, 3'd6, "dir_eq_count");
      chk("dir_eq_count_err", 16'(err), 16'd1);

      // 3. scan-up wrap
      cycle(1, 1, 1, 0, 1, 3'd4, "load4");
      cycle(1, 1, 0, 1, 1, 3'd0, "up_5");
      chk("up_5_sel", 16'(sel), 16'd5);
      chk("up_5_wrap", 16'(wrap), 16'd0);
      cycle(1, 1, 0, 1, 1, 3'd0, "up_0");
      chk("up_0_sel", 16'(sel), 16'd0);
      chk("up_0_wrap", 16'(wrap), 16'd1);
      chk("up_0_d", 16'(d), 16'b000001);
      cycle(1, 1, 0, 1, 1, 3'd0, "up_1");
      chk("up_1_sel", 16'(sel), 16'd1);
      chk("up_1_wrap", 16'(wrap), 16'd0);

      // 4. scan-down wrap from 0
      cycle(1, 1, 0, 1, 0, 3'd0, "dn_0");
      chk("dn_0_sel", 16'(sel), 16'd0);
      cycle(1, 1, 0, 1, 0, 3'd0, "dn_5");
      chk("dn_5_sel", 16'(sel), 16'd5);
      chk("dn_5_d", 16'(d), 16'b100000);
      chk("dn_5_wrap", 16'(wrap), 16'd1);

      // 5. priority and invalid load
      cycle(1, 1, 1, 1, 1, 3'd2, "ld_over_step");
      chk("ld_over_step_sel", 16'(sel), 16'd2);
      cycle(1, 1, 1, 1, 1, 3'd6, "ld_bad");
      chk("ld_bad_sel", 16'(sel), 16'd2);
      chk("ld_bad_err", 16'(err), 16'd1);
      chk("ld_bad_wrap", 16'(wrap), 16'd0);

      // 6. ena gating
      cycle(0, 1, 0, 1, 1, 3'd0, "ena0_a");
      cycle(0, 1, 0, 1, 1, 3'd0, "ena0_b");
      chk("ena0_d", 16'(d), 16'd0);
      chk("ena0_sel", 16'(sel), 16'd2);
      cycle(1, 1, 0, 0, 1, 3'd0, "ena_back");
      chk("ena_back_d", 16'(d), 16'b000100);

      // mode switch carries sel, then continuous scan with async reset
      cycle(1, 0, 0, 0, 0, 3'd3, "to_direct");
      cycle(1, 1, 0, 1, 1, 3'd0, "scan_a");
      cycle(1, 1, 0, 1, 1, 3'd0, "scan_b");
      chk("scan_b_sel", 16'(sel), 16'd5);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_scan", {d, sel, wrap, err}, 16'h0);
      m_sel = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      cycle(1, 1, 0, 1, 1, 3'd0, "resume_1");
      chk("resume_1_sel", 16'(sel), 16'd1);
      cycle(1, 1, 0, 1, 1, 3'd0, "resume_2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcn_seq.md
# dcn_seq

Parametrised registered binary-to-one-hot decoder with an integrated select sequencer. It generalises the 2-to-4 enable-gated decoder to COUNT outputs, which need not be a power of two. Sequencing runs in direct mode (select follows the input bus) or scan mode (select loads or steps up/down with wrap-around). Typical uses are chip-select generation, round-robin channel strobing and display-digit scanning.

## Interface
Parameters:
- W, default 3: select width in bits; legal range 1..8.
- COUNT, default 8: number of one-hot outputs; legal range 2..2**W.

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- ena, input, 1: global enable; when low, state freezes and outputs are forced to 0.
- mode, input, 1: 0 = direct, 1 = scan.
- load, input, 1: scan mode only; load `a` into the select register.
- step, input, 1: scan mode only; advance the select register one position.
- up, input, 1: step direction; 1 = increment, 0 = decrement.
- a, input, W: select value (direct mode) or load value (scan mode).
- d, output, COUNT: registered one-hot decode of the select register.
- sel, output, W: current select register.
- wrap, output, 1: one-cycle pulse when a step wraps around.
- err, output, 1: one-cycle pulse when `a` is out of range (a >= COUNT).

## Operation
- **State.** The only state is `sel` (W bits). The outputs `d`, `wrap` and `err` are registered. `sel_n` denotes the next value of `sel`.
- **Reset (async, any time, including mid-scan).** sel = 0, d = 0, wrap = 0, err = 0.
- **ena = 0.**
  - sel holds; load, step, mode and a are ignored.
  - d = 0, wrap = 0 and err = 0 at the next edge.
- **ena = 1, mode = 0 (direct).**
  - If a < COUNT: sel_n = a.
  - Otherwise sel_n = sel and err = 1.
  - step, load and up are ignored.
- **ena = 1, mode = 1 (scan).** Priority is load > step > hold.
  - **load = 1, a < COUNT:** sel_n = a.
  - **load = 1, a >= COUNT:** sel_n = sel and err = 1. A step asserted in the same cycle is discarded, not executed.
  - **step = 1, up = 1:** sel_n = sel + 1 if sel < COUNT-1. Otherwise sel_n = 0 and wrap = 1.
  - **step = 1, up = 0:** sel_n = sel - 1 if sel > 0. Otherwise sel_n = COUNT-1 and wrap = 1.
  - **Neither load nor step:** sel_n = sel.
- **Decode.**
  - With ena = 1: d <= (1 << sel_n), exactly one bit set.
  - With ena = 0: d <= 0.
  - d is never multi-hot. d is all-zero only after reset or when ena = 0.
- **Out-of-range sel.** Unreachable by construction. Arithmetic is done in W bits, and wrap is detected by compare against COUNT-1 and 0, never by overflow.
- **Output pulse widths.** wrap and err are single-cycle. They are cleared on any cycle without a fresh event.
- **Mode switches.** Take effect on the same edge. sel carries across the switch unchanged unless the new mode's rule changes it.

## Timing
- **Latency.** 1 cycle from input sampling to d/sel/wrap/err. d and sel always update on the same edge and are mutually consistent (d == 1 << sel whenever d != 0).
- **ena re-assert.** The first edge with ena = 1 produces d = 1 << sel_n; there is no dead cycle.
- **Stepping rate.** Back-to-back steps are allowed every cycle. Holding step high scans one position per clock.
- **Reset release.** The first edge after release evaluates normally, with sel = 0 as the starting point.
- **Paths.** No combinational path from any input to any output.

## Test plan
Configuration for all scenarios: W = 3, COUNT = 6.

1. **Reset and direct mode.** Assert rst mid-cycle; then mode = 0, ena = 1, a = 4 for one edge.
   - While rst is high: d = 0, sel = 0, wrap = 0, err = 0 immediately, without waiting for an edge.
   - After the edge: d = 6'b010000, sel = 4.
2. **Direct mode out of range.** From sel = 4, apply a = 7.
   - Required: sel stays 4, d stays 6'b010000, err = 1 for exactly one cycle.
3. **Scan-up wrap.** load with a = 4, then step = 1, up = 1 held for 3 cycles.
   - Required sel sequence: 5, 0, 1.
   - wrap = 1 only on the edge where sel becomes 0; d = 6'b000001 at that edge.
4. **Scan-down wrap.** From sel = 0, step = 1, up = 0.
   - Required: sel = 5, d = 6'b100000, wrap = 1.
5. **Priority and invalid load.**
   - load = 1, step = 1, a = 2: sel = 2, no step taken.
   - load = 1, step = 1, a = 6: sel holds, err = 1, wrap = 0.
6. **ena gating and async reset mid-scan.**
   - ena = 0 with step = 1 for 2 cycles: d = 0, sel frozen.
   - ena back to 1: d = 1 << sel on the first edge.
   - Async rst during a continuous scan: all outputs = 0 immediately; scan resumes from sel = 0 after release.
